rom_download_sched: RTL and testbench
=====================================

Name: rom_download_sched

Overview:
- Sequences ROM image bytes from the data_io ioctl stream into the two SDRAM write ports. Port1 carries the CPU program ROM region; port2 carries the 32-bit-merged background/sprite ROM region.
- Uses the sdram toggle req/ack handshake. Buffers bytes in a 2-entry FIFO while a port is busy.
- Owns the rom_loaded flag and the core hold-reset that bombjack_top needs.
- Sits between data_io and sdram, clocked on the 48 MHz system clock.

Parameters:
- BG_BASE, 25'h00E000, first ioctl byte address of the background ROM region.
- BG_SIZE, 25'h008000, byte length of the background region; bytes at addresses >= BG_BASE+BG_SIZE are discarded.
- RST_HOLD, 16, clk_sys cycles core_reset stays high after the download ends.

Ports:
- clk_sys  in  1  system clock (48 MHz)
- reset  in  1  synchronous, active-high reset
- ioctl_downl  in  1  download active (level)
- ioctl_wr  in  1  byte strobe; rising edge = new byte
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- port1_req  out  1  toggle request, CPU ROM port
- port1_ack  in  1  toggle ack; equals port1_req when idle
- port1_a  out  23  word address
- port1_ds  out  2  byte select {hi,lo}
- port1_d  out  16  {byte,byte}
- port2_req  out  1  toggle request, BG port
- port2_ack  in  1  toggle ack
- port2_a  out  14  word address
- port2_ds  out  2  byte select
- port2_d  out  16  {byte,byte}
- port_we  out  1  write enable to both ports; equals ioctl_downl registered
- rom_loaded  out  1  set on completed download, sticky
- core_reset  out  1  hold-reset for the game core
- overrun  out  1  sticky: byte dropped because FIFO full

Behaviour:
- Reset values:
  - port1_req = port2_req = 0; a, ds and d outputs = 0.
  - port_we = 0, rom_loaded = 0, core_reset = 1, overrun = 0.
  - FIFO empty, FSM in IDLE.
- Edge detect: a byte is captured on the cycle ioctl_wr is 1 and was 0 on the previous cycle, only while ioctl_downl = 1. Captured data is {addr, data}. The capture pushes into the FIFO.
- FIFO: 2 entries, 1 push and 1 pop per cycle.
  - Simultaneous push and pop while full is allowed; count is unchanged.
  - Push while full with no pop drops the byte and sets overrun.
- Routing at issue time:
  - addr < BG_BASE: port1. port1_a = addr[23:1], ds = {addr[0], ~addr[0]}.
  - BG_BASE <= addr < BG_BASE+BG_SIZE: port2. Let off = addr - BG_BASE. port2_a = {off[12:0], off[14]}, ds = {off[13], ~off[13]}.
  - Otherwise: popped and discarded, no request.
  - In all cases d = {data, data}.
- FSM:
  - IDLE: if FIFO not empty, pop the head.
    - Routed entry: load that port's a/ds/d and toggle its req in the same cycle, then go to WAIT.
    - Discarded entry: stay in IDLE.
  - WAIT: stay until the active port's ack == req. Then go to IDLE; the next issue happens one cycle later at the earliest.
  - Only one port outstanding at a time. a/ds/d are stable from the toggle cycle until ack matches.
- Latency: byte edge → FIFO write at +1 cycle → req toggle at +2 cycles, when idle.
- Download end: on the ioctl_downl falling edge, wait until the FIFO is empty and the FSM is in IDLE, then set rom_loaded. Bytes still in flight are completed first.
- core_reset:
  - Held high while ioctl_downl = 1, while draining, and while rom_loaded = 0.
  - Released RST_HOLD cycles after rom_loaded sets.
  - A new download re-asserts core_reset on the cycle ioctl_downl rises. rom_loaded stays 1 (sticky).
- reset mid-download: FIFO is flushed and the FSM goes to IDLE. Req bits return to 0; the sdram side must be re-initialised with ack = 0 by the same reset. rom_loaded clears.
- Stale ioctl_wr: ioctl_wr = 1 when ioctl_downl rises does not count as an edge unless ioctl_wr was seen 0 first.

Test Plan:
- CPU byte: downl = 1, wr edge at addr 0x0003, dout 0xA5 → port1_req toggles 2 cycles later with port1_a = 1, ds = 2'b10, d = 16'hA5A5. Hold ack for 5 cycles → no further req.
- BG byte: wr at addr 0xE000+0x6001 (off = 0x6001) → port2_a = {13'h0001, 1'b1} = 14'h0003, ds = 2'b10, port2_d = {dout, dout}. Port1 req unchanged.
- Back-pressure: 3 wr edges 2 cycles apart with ack withheld for 20 cycles → first byte issued, 2 buffered, overrun = 0. A 4th edge → overrun = 1, and exactly 3 reqs occur in total after acks.
- Out-of-range byte: addr 0x016000 → no req on either port, FIFO drains.
- Completion: downl falls with 1 byte queued → rom_loaded = 1 only after the final ack. core_reset falls exactly RST_HOLD cycles later.
- Reset during WAIT → all outputs at reset values next cycle, rom_loaded = 0, core_reset = 1.

Source files
------------

// File: rtl/rom_download_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rom_download_sched : routes data_io ROM bytes into the two sdram write ports
// Revision 1.0
// ---------------------------------------------------------------------------
module rom_download_sched #(
  parameter logic [24:0] BG_BASE  = 25'h00E000,
  parameter logic [24:0] BG_SIZE  = 25'h008000,
  parameter int          RST_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [13:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port_we,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overrun
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_nx;

  logic        wr_prev;
  logic        push, push_ok, pop;
  logic [32:0] fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic [24:0] head_addr, off;
  logic [7:0]  head_data;
  logic        to_p1, to_p2, issue1, issue2;
  logic        active, ack_match;
  logic        fell, drained, drain_pend;
  logic        hold;
  logic [HOLD_W-1:0] hold_cnt;

  // wr_prev resets high so a strobe already asserted is never taken as an edge
  assign push    = ioctl_downl & ioctl_wr & ~wr_prev;
  assign push_ok = push & ((count != 2'd2) | pop);

  assign head_addr = fifo_mem[rd_ptr][32:8];
  assign head_data = fifo_mem[rd_ptr][7:0];
  assign off       = head_addr - BG_BASE;
  assign to_p1     = head_addr < BG_BASE;
  assign to_p2     = !to_p1 && (off < BG_SIZE);

  assign ack_match = active ? (port2_ack == port2_req) : (port1_ack == port1_req);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    issue1   = 1'b0;
    issue2   = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != 2'd0) begin
          pop = 1'b1;
          if (to_p1) begin
            issue1   = 1'b1;
            state_nx = S_WAIT;
          end else if (to_p2) begin
            issue2   = 1'b1;
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (ack_match) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_prev <= 1'b1;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      overrun <= 1'b0;
    end else begin
      wr_prev <= ioctl_wr;
      if (push_ok) begin
        fifo_mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !push_ok) overrun <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
      active    <= 1'b0;
    end else if (issue1) begin
      port1_req <= ~port1_req;
      port1_a   <= head_addr[23:1];
      port1_ds  <= {head_addr[0], ~head_addr[0]};
      port1_d   <= {head_data, head_data};
      active    <= 1'b0;
    end else if (issue2) begin
      // BG words interleave: low offset bits form the row, bit 14 picks the bank half
      port2_req <= ~port2_req;
      port2_a   <= {off[12:0], off[14]};
      port2_ds  <= {off[13], ~off[13]};
      port2_d   <= {head_data, head_data};
      active    <= 1'b1;
    end
  end

  assign fell    = port_we & ~ioctl_downl;
  assign drained = (count == 2'd0) && (state == S_IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      port_we    <= 1'b0;
      rom_loaded <= 1'b0;
      drain_pend <= 1'b0;
    end else begin
      port_we <= ioctl_downl;
      if ((fell || drain_pend) && drained && !ioctl_downl) begin
        rom_loaded <= 1'b1;
        drain_pend <= 1'b0;
      end else if (fell) begin
        drain_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold     <= 1'b1;
      hold_cnt <= '0;
    end else if (ioctl_downl || port_we || drain_pend || !rom_loaded) begin
      hold     <= 1'b1;
      hold_cnt <= '0;
    end else if (hold) begin
      if (hold_cnt == HOLD_LAST) hold <= 1'b0;
      else                       hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // a new download must stop the core in the very cycle it begins
  assign core_reset = hold | ioctl_downl;

endmodule
`default_nettype wire

// File: tb/tb_rom_download_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rom_download_sched : vector table, corner sequences and randomized model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_rom_download_sched;

  localparam int unsigned BG_BASE  = 32'h00E000;
  localparam int unsigned BG_SIZE  = 32'h008000;
  localparam int          RST_HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_downl, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_ack, port2_req, port2_ack;
  logic [22:0] port1_a;
  logic [13:0] port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic        port_we, rom_loaded, core_reset, overrun;

  rom_download_sched dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds),
    .port1_d(port1_d), .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d), .port_we(port_we), .rom_loaded(rom_loaded),
    .core_reset(core_reset), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          port;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } obs_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    int          port;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } vec_t;

  obs_t obs_q[$];
  obs_t exp_q[$];
  vec_t vecs[10];

  int vectors = 0;
  int miscompares = 0;
  bit ack_hold = 1'b0;
  int ack_lat = 1;
  int c1 = 0, c2 = 0;
  logic prev1 = 1'b0, prev2 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic apply_byte(input logic [24:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    step(1);
    ioctl_wr   = 1'b0;
    step(1);
  endtask

  function automatic logic [63:0] pack(input obs_t o);
    return 64'({o.port[3:0], o.a, o.ds, o.d});
  endfunction

  // Reference: each routed byte becomes one request, in arrival order.
  function automatic obs_t model(input logic [24:0] addr, input logic [7:0] data);
    obs_t r;
    int unsigned ad, off;
    ad = addr;
    r.port = 0; r.a = '0; r.ds = '0; r.d = '0;
    if (ad < BG_BASE) begin
      r.port = 1;
      r.a    = 23'(ad / 2);
      r.ds   = (ad % 2 == 1) ? 2'b10 : 2'b01;
      r.d    = {data, data};
    end else if (ad < BG_BASE + BG_SIZE) begin
      off    = ad - BG_BASE;
      r.port = 2;
      r.a    = 23'((off % 8192) * 2 + (off / 16384) % 2);
      r.ds   = ((off / 8192) % 2 == 1) ? 2'b10 : 2'b01;
      r.d    = {data, data};
    end
    return r;
  endfunction

  // sdram stand-in: acks after ack_lat cycles, cleared by the shared reset
  initial begin
    port1_ack = 1'b0;
    port2_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2;
      if (reset) begin
        port1_ack = 1'b0; port2_ack = 1'b0; c1 = 0; c2 = 0;
      end else if (!ack_hold) begin
        if (port1_ack != port1_req) begin
          if (c1 >= ack_lat) begin port1_ack = port1_req; c1 = 0; end
          else c1++;
        end
        if (port2_ack != port2_req) begin
          if (c2 >= ack_lat) begin port2_ack = port2_req; c2 = 0; end
          else c2++;
        end
      end
    end
  end

  initial begin
    obs_t o;
    forever begin
      @(posedge clk_sys);
      #3;
      if (port1_req !== prev1) begin
        o.port = 1; o.a = port1_a; o.ds = port1_ds; o.d = port1_d;
        obs_q.push_back(o);
      end
      if (port2_req !== prev2) begin
        o.port = 2; o.a = {9'd0, port2_a}; o.ds = port2_ds; o.d = port2_d;
        obs_q.push_back(o);
      end
      prev1 = port1_req;
      prev2 = port2_req;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    obs_t e;
    vecs[0] = '{25'h000003, 8'hA5, 1, 23'h000001, 2'b10, 16'hA5A5};
    vecs[1] = '{25'h000000, 8'h3C, 1, 23'h000000, 2'b01, 16'h3C3C};
    vecs[2] = '{25'h00DFFF, 8'h11, 1, 23'h006FFF, 2'b10, 16'h1111};
    vecs[3] = '{25'h00E000, 8'h22, 2, 23'h000000, 2'b01, 16'h2222};
    vecs[4] = '{25'h014001, 8'h5A, 2, 23'h000003, 2'b10, 16'h5A5A};
    vecs[5] = '{25'h015FFF, 8'h77, 2, 23'h003FFF, 2'b10, 16'h7777};
    vecs[6] = '{25'h016000, 8'h01, 0, 23'h0, 2'b00, 16'h0};
    vecs[7] = '{25'h1FFFFFF, 8'h02, 0, 23'h0, 2'b00, 16'h0};
    vecs[8] = '{25'h012000, 8'h99, 2, 23'h000001, 2'b01, 16'h9999};
    vecs[9] = '{25'h010002, 8'hC3, 2, 23'h000004, 2'b10, 16'hC3C3};

    reset = 1'b1; ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    step(3);
    check("rst_port1_req", port1_req, 0);
    check("rst_port2_req", port2_req, 0);
    check("rst_port1_a", port1_a, 0);
    check("rst_port_we", port_we, 0);
    check("rst_rom_loaded", rom_loaded, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    step(1);

    // first CPU byte: exact two-cycle latency, and no repeat while ack lags
    ioctl_downl = 1'b1;
    step(2);
    check("port_we_follows", port_we, 1);
    ack_hold = 1'b1;
    ioctl_addr = 25'h3; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
    step(1);
    check("lat_req_not_yet", port1_req, 0);
    ioctl_wr = 1'b0;
    step(1);
    check("lat_req_toggled", port1_req, 1);
    check("lat_port1_a", port1_a, 23'h1);
    check("lat_port1_ds", port1_ds, 2'b10);
    check("lat_port1_d", port1_d, 16'hA5A5);
    step(5);
    check("no_extra_req", obs_q.size(), 1);
    check("core_reset_dl", core_reset, 1);
    ack_hold = 1'b0;
    step(6);
    obs_q.delete();

    foreach (vecs[i]) begin
      apply_byte(vecs[i].addr, vecs[i].data);
      step(10);
      if (vecs[i].port == 0) begin
        check($sformatf("vec%0d_no_req", i), obs_q.size(), 0);
      end else begin
        check($sformatf("vec%0d_count", i), obs_q.size(), 1);
        if (obs_q.size() == 1) begin
          e.port = vecs[i].port; e.a = vecs[i].a; e.ds = vecs[i].ds; e.d = vecs[i].d;
          check($sformatf("vec%0d_req", i), pack(obs_q[0]), pack(e));
        end
      end
      obs_q.delete();
    end

    // back-pressure: one issued, two buffered, fourth dropped
    ack_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply_byte(25'h100 + 25'(2 * k), 8'(k));
      if (k == 2) check("bp_no_overrun", overrun, 0);
      if (k == 3) check("bp_overrun", overrun, 1);
    end
    step(14);
    ack_hold = 1'b0;
    step(30);
    check("bp_req_total", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("bp_a0", obs_q[0].a, 23'h80);
      check("bp_a1", obs_q[1].a, 23'h81);
      check("bp_a2", obs_q[2].a, 23'h82);
    end
    obs_q.delete();

    // completion with one byte still queued behind an outstanding request
    ack_hold = 1'b1;
    apply_byte(25'h200, 8'h11);
    apply_byte(25'h202, 8'h22);
    ioctl_downl = 1'b0;
    step(5);
    check("done_not_early", rom_loaded, 0);
    check("done_core_reset", core_reset, 1);
    ack_hold = 1'b0;
    t = 0;
    while (!rom_loaded && t < 50) begin step(1); t++; end
    check("done_rom_loaded", rom_loaded, 1);
    check("done_reqs", obs_q.size(), 2);
    check("done_ack_match", port1_ack, port1_req);
    t = 0;
    while (core_reset && t < 100) begin step(1); t++; end
    check("core_reset_hold", t, RST_HOLD);
    obs_q.delete();

    // new download with stale strobe already high
    ioctl_wr = 1'b1; ioctl_addr = 25'h300; ioctl_dout = 8'h44;
    step(2);
    ioctl_downl = 1'b1;
    #1;
    check("core_reset_reassert", core_reset, 1);
    check("rom_loaded_sticky", rom_loaded, 1);
    step(6);
    check("stale_wr_ignored", obs_q.size(), 0);
    ioctl_wr = 1'b0;
    step(1);
    ioctl_wr = 1'b1;
    step(1);
    ioctl_wr = 1'b0;
    step(8);
    check("fresh_wr_taken", obs_q.size(), 1);
    obs_q.delete();

    // randomized bytes against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [24:0] ad;
      logic [7:0]  dt;
      int          reg_sel;
      reg_sel = $urandom_range(0, 2);
      if (reg_sel == 0)      ad = 25'($urandom_range(0, BG_BASE - 1));
      else if (reg_sel == 1) ad = 25'(BG_BASE + $urandom_range(0, BG_SIZE - 1));
      else                   ad = 25'(BG_BASE + BG_SIZE + $urandom_range(0, 32'hFFFF));
      dt = 8'($urandom);
      e = model(ad, dt);
      if (e.port != 0) exp_q.push_back(e);
      ack_lat = $urandom_range(0, 4);
      apply_byte(ad, dt);
      step(ack_lat + 8);
    end
    step(10);
    check("rand_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("rand_req%0d", i), pack(obs_q[i]), pack(exp_q[i]));
    check("rand_overrun", overrun, 1);
    obs_q.delete();
    ack_lat = 1;

    // reset while a port2 request is outstanding
    ack_hold = 1'b1;
    apply_byte(25'h00E004, 8'h5A);
    reset = 1'b1;
    ioctl_downl = 1'b0;
    step(1);
    check("wrst_port1_req", port1_req, 0);
    check("wrst_port2_req", port2_req, 0);
    check("wrst_port2_a", port2_a, 0);
    check("wrst_port2_ds", port2_ds, 0);
    check("wrst_port2_d", port2_d, 0);
    check("wrst_port_we", port_we, 0);
    check("wrst_rom_loaded", rom_loaded, 0);
    check("wrst_core_reset", core_reset, 1);
    check("wrst_overrun", overrun, 0);
    reset = 1'b0;
    ack_hold = 1'b0;
    step(3);
    check("post_rst_loaded", rom_loaded, 0);
    check("post_rst_core_reset", core_reset, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
